// File: rtl/mux_2to1.sv
// mux_2to1: one-bit 2:1 multiplexer with a combinational output and a
// registered shadow of the output and select, plus an optional saturating
// count of select switches.
//
// Build option: define MUX_SWCNT_EN to build the select-switch counter;
// when undefined, sw_cnt is tied to zero and no counter flops exist.
//
// Ports:
//   clk     in   1      rising-edge clock for all registered state
//   rst_n   in   1      asynchronous active-low reset
//   din     in   2      data inputs; din[sel] is selected
//   sel     in   1      select
//   dout    out  1      combinational din[sel]
//   dout_q  out  1      dout registered on clk
//   sel_q   out  1      sel registered on clk
//   sw_cnt  out  CNT_W  saturating count of edges where sel != sel_q
module mux_2to1 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       din,
    input  logic             sel,
    output logic             dout,
    output logic             dout_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] sw_cnt
);

    // Indexing by sel keeps an X/Z select visible as X on dout, where a
    // ternary would merge equal data inputs and hide it.
    assign dout = din[sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= 1'b0;
            sel_q  <= 1'b0;
        end else begin
            dout_q <= dout;
            sel_q  <= sel;
        end
    end

`ifdef MUX_SWCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_cnt <= '0;
        end else if ((sel != sel_q) && (sw_cnt != '1)) begin
            sw_cnt <= sw_cnt + 1'b1;
        end
    end
`else
    assign sw_cnt = '0;
`endif

endmodule

// File: tb/tb_mux_2to1.sv
`timescale 1ns/1ps
module tb_mux_2to1;

`ifdef MUX_SWCNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] din;
    logic       sel;

    logic       dout, dout_q, sel_q;
    logic [7:0] sw_cnt;
    logic       s_dout, s_dout_q, s_sel_q;
    logic [1:0] s_sw_cnt;

    int checks = 0;
    int errors = 0;

    mux_2to1 #(.CNT_W(8)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .sel    (sel),
        .dout   (dout),
        .dout_q (dout_q),
        .sel_q  (sel_q),
        .sw_cnt (sw_cnt)
    );

    mux_2to1 #(.CNT_W(2)) u_sat (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .sel    (sel),
        .dout   (s_dout),
        .dout_q (s_dout_q),
        .sel_q  (s_sel_q),
        .sw_cnt (s_sw_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_regs(input string tag, input logic dq, input logic sq,
                            input int cnt, input int scnt);
        chk({tag, ".dout_q"}, 16'(dout_q), 16'(dq));
        chk({tag, ".sel_q"},  16'(sel_q),  16'(sq));
        chk({tag, ".sw_cnt"}, 16'(sw_cnt), EN ? 16'(cnt) : 16'd0);
        chk({tag, ".s_dout_q"}, 16'(s_dout_q), 16'(dq));
        chk({tag, ".s_sw_cnt"}, 16'(s_sw_cnt), EN ? 16'(scnt) : 16'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        din   = 2'b00;
        sel   = 1'b0;
        #1;
        chk_regs("reset", 1'b0, 1'b0, 0, 0);

        // combinational truth sequence, all within one clock half-period
        din = 2'b01; sel = 1'b0; #1 chk("comb0", 16'(dout), 16'd1);
        sel = 1'b1;              #1 chk("comb1", 16'(dout), 16'd0);
        din = 2'b11;             #1 chk("comb2", 16'(dout), 16'd1);
        din = 2'b10;             #1 chk("comb3", 16'(dout), 16'd1);
        sel = 1'b0;              #1 chk("comb4", 16'(dout), 16'd0);
        chk("comb4.s", 16'(s_dout), 16'd0);

        // registered latency
        @(negedge clk);
        rst_n = 1'b1;
        din   = 2'b10;
        sel   = 1'b0;
        step();
        chk_regs("lat_e1", 1'b0, 1'b0, 0, 0);
        sel = 1'b1;
        #1;
        chk("lat_pre.dout", 16'(dout), 16'd1);
        chk_regs("lat_pre", 1'b0, 1'b0, 0, 0);
        step();
        chk_regs("lat_post", 1'b1, 1'b1, 1, 1);

        // build up to dout_q=1, sw_cnt=3
        sel = 1'b0; step();
        chk_regs("pre_rst1", 1'b0, 1'b0, 2, 2);
        sel = 1'b1; step();
        chk_regs("pre_rst2", 1'b1, 1'b1, 3, 3);

        // asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1;
        chk_regs("async_rst", 1'b0, 1'b0, 0, 0);
        chk("async_rst.dout", 16'(dout), 16'd1);
        sel = 1'b0;
        #1 chk("async_rst.dout2", 16'(dout), 16'd0);
        step();
        chk_regs("rst_held", 1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;

        // switch counting: 5 toggles then hold 3 cycles; din=10 so dout_q == sel
        for (int i = 1; i <= 5; i++) begin
            sel = ~sel;
            step();
            chk_regs($sformatf("sw%0d", i), sel, sel, i, (i > 3) ? 3 : i);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            chk_regs($sformatf("hold%0d", i), 1'b1, 1'b1, 5, 3);
        end

        // saturation on the 2-bit instance after a fresh reset
        rst_n = 1'b0;
        sel   = 1'b0;
        #1;
        chk("sat_rst", 16'(s_sw_cnt), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            sel = ~sel;
            step();
            chk_regs($sformatf("sat%0d", i), sel, sel, i, (i > 3) ? 3 : i);
            chk($sformatf("sat%0d.s_sel_q", i), 16'(s_sel_q), 16'(sel));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_2to1.md
# mux_2to1

Two-input, one-bit multiplexer with a combinational data path and a registered, clocked shadow of its output and select. `dout` follows `din[sel]` with zero clock latency, so it can sit directly in combinational datapaths. The registered outputs give downstream synchronous logic a clean, reset-defined copy of the selection result and a count of select changes. The block is a leaf cell with no submodules.

## Interface
Parameters:
- `CNT_W`, default 8, width of the select-switch counter (valid range 1–16).

Ports:
- `clk`, input, 1, rising-edge clock for all registered state.
- `rst_n`, input, 1, reset; one clock, asynchronous active-low reset.
- `din`, input, 2, data inputs; `din[0]` is selected when `sel`=0 and `din[1]` when `sel`=1.
- `sel`, input, 1, select.
- `dout`, output, 1, combinational result `din[sel]`.
- `dout_q`, output, 1, `dout` registered on the rising edge of `clk`.
- `sel_q`, output, 1, `sel` registered on the rising edge of `clk`.
- `sw_cnt`, output, `CNT_W`, saturating count of clock edges at which `sel` differs from `sel_q`.

## Operation
- `dout` = `sel ? din[1] : din[0]`; purely combinational, independent of `clk` and `rst_n`.
- When `sel` or `din` is X or Z, `dout` is X; do not mask it.
- While `rst_n` is low, `dout_q`, `sel_q` and `sw_cnt` are 0, regardless of `clk`.
- On each rising `clk` edge with `rst_n` high:
  - `dout_q` <= `dout`.
  - `sel_q` <= `sel`.
  - If `sel` != `sel_q`, `sw_cnt` increments by 1 and saturates at all-ones (no wrap).
- The first edge after reset release compares `sel` against `sel_q`=0, so `sel`=1 at that edge counts as a switch.
- No handshake; inputs are sampled every cycle.

## Timing
- `dout`: zero-cycle latency, combinational path from `din` and `sel` only.
- `dout_q` and `sel_q`: one-cycle latency.
- `sw_cnt` reflects a switch one edge after `sel` changes.
- Reset assertion clears the registers immediately, without waiting for a clock edge, and the clear takes effect mid-operation.
- Reset release is synchronized by the user; the block itself has no reset synchronizer.
- Saturation: at `sw_cnt` = 2^CNT_W−1, further switches leave it unchanged.

## Configuration
- Macro `MUX_SWCNT_EN`.
- Defined: `sw_cnt` logic is built as described above.
- Undefined:
  - `sw_cnt` is tied to constant 0 and no counter flops are inferred.
  - `dout`, `dout_q` and `sel_q` behave identically in both builds.

## Test plan
- Combinational truth sequence: `din`=01/`sel`=0 gives `dout`=1; then `sel`=1 gives 0; then `din`=11 gives 1; then `din`=10 gives 1; then `sel`=0 gives 0. Each result is checked with no clock edge in between.
- Registered latency: `din`=10, `sel` steps 0→1 before edge N, so `dout_q`=1 and `sel_q`=1 after edge N and 0 before it.
- Async reset mid-run: with `dout_q`=1 and `sw_cnt`=3, pull `rst_n` low between edges; all three outputs go to 0 immediately while `dout` still tracks `din[sel]`.
- Switch counting: toggle `sel` on 5 consecutive cycles, then hold for 3, giving `sw_cnt`=5 and no further change.
- Saturation: `CNT_W`=2, toggle `sel` 6 times, giving `sw_cnt` of 1, 2, 3, 3, 3, 3.
- Macro off: repeat the switch-counting test with `MUX_SWCNT_EN` undefined; `sw_cnt` stays 0 throughout and all other outputs match the macro-on run.
